instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Sequential instruction source for the control unit and decode stage. It owns the PC and fetches one word per instruction over a req/ack instruction-memory handshake, then presents the registered instruction with a valid flag. It consumes the decoder's branch decision (PCsrc) and the sign-extended branch offset (ImmOp) to select the next PC. Misaligned PCs and memory timeouts trap into a sticky fault state.

Parameters:
DATA_WIDTH, 32, instruction/immediate width
ADDR_WIDTH, 32, PC and imem address width
RESET_PC, 32'h0, PC value loaded on reset
TIMEOUT, 16, max cycles in FETCH without ack before fault; 0 disables the watchdog

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
PCsrc  input  1  branch taken for current Instr, valid only while InstrValid=1
ImmOp  input  DATA_WIDTH  sign-extended branch offset for current Instr
Stall  input  1  downstream cannot consume current Instr this cycle
imem_req  output  1  fetch request; held until ack
imem_addr  output  ADDR_WIDTH  fetch address (= PC), stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  DATA_WIDTH  fetched word
Instr  output  DATA_WIDTH  registered instruction to control unit
InstrValid  output  1  Instr holds a fetched, unconsumed instruction
PC  output  ADDR_WIDTH  address of Instr / pending fetch
Fault  output  1  sticky misalign/timeout trap

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, Instr=32'h00000013 (NOP), InstrValid=0, imem_req=0, Fault=0, timeout counter=0.
- States: IDLE, FETCH, VALID, FAULT. imem_req = (state==FETCH); imem_addr = PC.
- IDLE: unconditional move to FETCH next cycle. First request appears in the first cycle after rst_n rises, plus one cycle.
- FETCH: on imem_ack=1, Instr<=imem_rdata, InstrValid<=1, move to VALID. Ack in the same cycle as req is legal, giving a 1-cycle fetch.
- FETCH timeout: counter clears on entry and increments each cycle without ack. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack, move to FAULT. An ack in that same cycle wins over the timeout.
- VALID, Stall=1: Instr, PC and InstrValid hold. No request is issued.
- VALID, Stall=0: the instruction is consumed this cycle.
  - next = PCsrc ? PC + ImmOp[ADDR_WIDTH-1:0] : PC + 4, mod 2^ADDR_WIDTH (wrap, no overflow flag).
  - If next[1:0]!=0: Fault<=1, state FAULT, PC unchanged.
  - Otherwise: PC<=next, InstrValid<=0, state FETCH.
- PCsrc and ImmOp are sampled only in VALID with Stall=0 and are ignored otherwise.
- FAULT: imem_req=0, InstrValid=0, Fault=1, all registers hold. The only exit is reset.
- imem_ack outside FETCH is ignored and does not update Instr.
- Reset mid-fetch drops the request immediately (async); the outstanding ack is ignored.
- Throughput: 2 cycles/instruction minimum (FETCH with same-cycle ack, then VALID).

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> during reset PC=0, InstrValid=0, imem_req=0, Fault=0; imem_req=1 with imem_addr=0 in the 2nd cycle after release.
2. Sequential fetch: ack in the req cycle with rdata=32'h00500093, Stall=0, PCsrc=0 -> next cycle Instr=32'h00500093 and InstrValid=1; following cycle imem_addr=0x4 with req=1.
3. Taken branch: PC=0x8, Instr valid, PCsrc=1, ImmOp=32'hFFFFFFF8 -> next request at imem_addr=0x0. Also: PC=32'hFFFFFFFC, PCsrc=0 -> next imem_addr=0x0 (wrap).
4. Stall: Stall=1 for 3 cycles while VALID -> Instr, PC and InstrValid=1 unchanged, imem_req=0 throughout; first request follows Stall deassertion by one cycle.
5. Misaligned branch: PC=0x10, PCsrc=1, ImmOp=0x6 -> Fault=1 next cycle, PC stays 0x10, imem_req stays 0 for 20 cycles until rst_n pulse clears it.
6. Timeout: TIMEOUT=8, never ack -> imem_req high for exactly 8 cycles, then Fault=1, imem_req=0. Repeat with ack on the 8th cycle -> no fault, Instr loaded.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over a
// req/ack handshake, and traps misaligned PCs and memory timeouts into a sticky fault.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         PCsrc,
  input  logic signed [DATA_WIDTH-1:0] ImmOp,
  input  logic                         Stall,
  output logic                         imem_req,
  output logic        [ADDR_WIDTH-1:0] imem_addr,
  input  logic                         imem_ack,
  input  logic        [DATA_WIDTH-1:0] imem_rdata,
  output logic        [DATA_WIDTH-1:0] Instr,
  output logic                         InstrValid,
  output logic        [ADDR_WIDTH-1:0] PC,
  output logic                         Fault
);

  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(32'h0000_0013);
  localparam int                    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]         TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_t;

  state_t                         state;
  logic          [CW-1:0]         wait_cnt;
  logic signed   [ADDR_WIDTH-1:0] offset;
  logic          [ADDR_WIDTH-1:0] next_pc;

  // Branch target arithmetic wraps modulo 2^ADDR_WIDTH; no overflow is reported.
  function automatic logic [ADDR_WIDTH-1:0] target_pc(
    input logic        [ADDR_WIDTH-1:0] pc,
    input logic                         taken,
    input logic signed [ADDR_WIDTH-1:0] off
  );
    if (taken) return pc + $unsigned(off);
    return pc + ADDR_WIDTH'(4);
  endfunction

  assign offset    = signed'(ImmOp[ADDR_WIDTH-1:0]);
  assign next_pc   = target_pc(PC, PCsrc, offset);
  assign imem_req  = (state == FETCH);
  assign imem_addr = PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      Instr      <= NOP;
      InstrValid <= 1'b0;
      Fault      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          wait_cnt <= '0;
        end
        FETCH: begin
          // An ack arriving on the last allowed cycle still beats the watchdog.
          if (imem_ack) begin
            Instr      <= imem_rdata;
            InstrValid <= 1'b1;
            state      <= VALID;
          end else if (TIMEOUT != 0 && wait_cnt == TMAX) begin
            Fault <= 1'b1;
            state <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        VALID: begin
          if (!Stall) begin
            if (next_pc[1:0] != 2'b00) begin
              Fault      <= 1'b1;
              InstrValid <= 1'b0;
              state      <= FAULT;
            end else begin
              PC         <= next_pc;
              InstrValid <= 1'b0;
              wait_cnt   <= '0;
              state      <= FETCH;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed stimulus, a behavioural
// reference model compared every cycle, and literal expectations at key points.
module tb_instr_fetch_unit;

  localparam int          TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCsrc = 1'b0;
  logic        Stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, InstrValid, Fault;
  logic [31:0] imem_addr, Instr, PC;

  int checks = 0;
  int errors = 0;
  int ack_lat = 0;
  int req_cycles = 0;
  int cnt;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .ImmOp(ImmOp), .Stall(Stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Instr(Instr), .InstrValid(InstrValid),
    .PC(PC), .Fault(Fault)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: tracks what the unit must be holding from the rules alone.
  logic [31:0] m_pc = 32'h0, m_instr = NOP;
  bit          m_valid = 0, m_fault = 0, m_started = 0;
  int          m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nxt;
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = NOP; m_valid = 0; m_fault = 0; m_started = 0; m_wait = 0;
    end else if (m_fault) begin
      m_wait = m_wait;
    end else if (!m_started) begin
      m_started = 1; m_wait = 0;
    end else if (!m_valid) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_valid = 1;
      end else if (m_wait == TO - 1) begin
        m_fault = 1;
      end else begin
        m_wait++;
      end
    end else if (!Stall) begin
      nxt = PCsrc ? m_pc + ImmOp : m_pc + 32'd4;
      if (nxt % 4 != 0) m_fault = 1;
      else begin
        m_pc = nxt; m_valid = 0; m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_req",   imem_req,   m_started && !m_valid && !m_fault);
    chk("mdl_addr",  imem_addr,  m_pc);
    chk("mdl_pc",    PC,         m_pc);
    chk("mdl_instr", Instr,      m_instr);
    chk("mdl_valid", InstrValid, m_valid && !m_fault);
    chk("mdl_fault", Fault,      m_fault);
  end

  // One clock, then the memory responder reacts to the settled request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imem_req) req_cycles++; else req_cycles = 0;
    imem_ack   = imem_req && (ack_lat >= 0) && (req_cycles == ack_lat + 1);
    imem_rdata = word_at(imem_addr);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !InstrValid; i++) tick();
    chk("wait_valid", InstrValid, 1'b1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_fault", Fault, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset hold and first request
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pc", PC, 32'h0);
      chk("rst_valid", InstrValid, 1'b0);
      chk("rst_req0", imem_req, 1'b0);
      chk("rst_instr", Instr, NOP);
    end
    rst_n = 1'b1;
    chk("first_cycle_req", imem_req, 1'b0);
    tick();
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);

    // Sequential fetch with same-cycle ack
    wait_valid();
    chk("seq_instr", Instr, 32'h0050_0093);
    chk("seq_req_low", imem_req, 1'b0);
    tick();
    chk("seq_req", imem_req, 1'b1);
    chk("seq_addr", imem_addr, 32'h4);

    // Taken backward branch, then wrap through the top of memory
    wait_valid(); tick();
    wait_valid();
    chk("br_pc", PC, 32'h8);
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    tick();
    chk("br_addr", imem_addr, 32'h0);
    chk("br_req", imem_req, 1'b1);
    PCsrc = 1'b0; ImmOp = 32'h0000_0002;
    wait_valid();
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;
    tick();
    chk("neg_pc", PC, 32'hFFFF_FFFC);
    PCsrc = 1'b0;
    wait_valid();
    chk("top_instr", Instr, 32'hFFFF_FFFC ^ 32'h1357_0000);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", imem_req, 1'b1);

    // Stall holds everything and ignores stray acks
    wait_valid();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", Instr, 32'h0050_0093);
      chk("stall_pc", PC, 32'h0);
      chk("stall_valid", InstrValid, 1'b1);
      chk("stall_req", imem_req, 1'b0);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end
    Stall = 1'b0;
    tick();
    chk("unstall_req", imem_req, 1'b1);
    chk("unstall_addr", imem_addr, 32'h4);

    // Misaligned branch traps and stays trapped
    wait_valid(); tick();
    wait_valid(); tick();
    wait_valid(); tick();
    wait_valid();
    chk("mis_pc0", PC, 32'h10);
    PCsrc = 1'b1; ImmOp = 32'h6;
    tick();
    PCsrc = 1'b0;
    chk("mis_fault", Fault, 1'b1);
    chk("mis_pc", PC, 32'h10);
    chk("mis_valid", InstrValid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mis_req_low", imem_req, 1'b0);
    end
    chk("mis_sticky", Fault, 1'b1);

    // Watchdog with no ack
    ack_lat = -1;
    reset_pulse();
    cnt = 0;
    for (int i = 0; i < 40 && !Fault; i++) begin
      tick();
      if (imem_req) cnt++;
    end
    chk("to_req_cycles", cnt, 8);
    chk("to_fault", Fault, 1'b1);
    chk("to_req_low", imem_req, 1'b0);

    // Ack on the final allowed cycle wins
    ack_lat = 7;
    reset_pulse();
    cnt = 0;
    for (int i = 0; i < 40 && !Fault && !InstrValid; i++) begin
      tick();
      if (imem_req) cnt++;
    end
    chk("late_req_cycles", cnt, 8);
    chk("late_fault", Fault, 1'b0);
    chk("late_valid", InstrValid, 1'b1);
    chk("late_instr", Instr, 32'h0050_0093);

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
